// File: rtl/step_pulse_gen.sv
// step_pulse_gen: pushbutton / free-run conditioner for the single-step clock enable.
//   Synchronizes the raw button and run switch, debounces presses and releases,
//   and issues a registered one-cycle step_en. In run mode step_en comes from a
//   free-running period counter instead. step_cnt counts issued pulses.
// Optional feature: define STEP_PULSE_AUTOREPEAT_EN to build hold auto-repeat
//   (HELD -> REPEAT after REPEAT_DELAY, then one pulse every REPEAT_PERIOD).
//   Without it, each accepted press gives exactly one pulse.
// Ports:
//   clk      in   board clock
//   rst      in   asynchronous active-low reset
//   pb       in   raw pushbutton (async, active-high)
//   run      in   raw free-run switch (async)
//   clr_cnt  in   synchronous clear of step_cnt
//   step_en  out  registered 1-cycle step pulse
//   pb_level out  debounced button level
//   step_cnt out  16-bit count of step_en pulses (wraps)
module step_pulse_gen #(
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned RUN_PERIOD    = 25000000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pb,
  input  logic        run,
  input  logic        clr_cnt,
  output logic        step_en,
  output logic        pb_level,
  output logic [15:0] step_cnt
);

  localparam int unsigned STEP_CNT_W = 16;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_PERIOD - 1);
`ifdef STEP_PULSE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`else
  // Repeat timing has no effect in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

`ifdef STEP_PULSE_AUTOREPEAT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PRESS_DB, S_HELD, S_REPEAT, S_RELEASE_DB
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PRESS_DB, S_HELD, S_RELEASE_DB
  } state_t;
`endif

  logic [1:0]            r_pb_sync;
  logic [1:0]            r_run_sync;
  logic                  w_pb_s;
  logic                  w_run_s;
  state_t                r_state;
  logic [CNT_W-1:0]      r_tc;
  logic                  r_pb_level;
  logic                  w_press;
  logic [CNT_W-1:0]      r_rc;
  logic                  r_run_pulse;
  logic                  r_step_en;
  logic [STEP_CNT_W-1:0] r_step_cnt;

  // Two-flop synchronizers for the asynchronous button and switch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pb_sync  <= '0;
      r_run_sync <= '0;
    end else begin
      r_pb_sync  <= {r_pb_sync[0], pb};
      r_run_sync <= {r_run_sync[0], run};
    end
  end

  assign w_pb_s  = r_pb_sync[1];
  assign w_run_s = r_run_sync[1];

  // Button debounce / hold FSM; tc restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tc       <= '0;
      r_pb_level <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pb_s) begin
            r_state <= S_PRESS_DB;
            r_tc    <= '0;
          end
        end
        S_PRESS_DB: begin
          if (!w_pb_s) begin
            r_state <= S_IDLE;
            r_tc    <= '0;
          end else if (r_tc == DB_LAST) begin
            r_state    <= S_HELD;
            r_tc       <= '0;
            r_pb_level <= 1'b1;
          end else begin
            r_tc <= r_tc + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!w_pb_s) begin
            r_state <= S_RELEASE_DB;
            r_tc    <= '0;
`ifdef STEP_PULSE_AUTOREPEAT_EN
          end else if (r_tc == REP_DLY_LAST) begin
            r_state <= S_REPEAT;
            r_tc    <= '0;
`endif
          end else begin
            r_tc <= r_tc + CNT_W'(1);
          end
        end
`ifdef STEP_PULSE_AUTOREPEAT_EN
        S_REPEAT: begin
          if (!w_pb_s) begin
            r_state <= S_RELEASE_DB;
            r_tc    <= '0;
          end else if (r_tc == REP_PER_LAST) begin
            r_tc <= '0;
          end else begin
            r_tc <= r_tc + CNT_W'(1);
          end
        end
`endif
        S_RELEASE_DB: begin
          // A bounce back high returns to HELD, which restarts the repeat delay.
          if (w_pb_s) begin
            r_state <= S_HELD;
            r_tc    <= '0;
          end else if (r_tc == DB_LAST) begin
            r_state    <= S_IDLE;
            r_tc       <= '0;
            r_pb_level <= 1'b0;
          end else begin
            r_tc <= r_tc + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tc    <= '0;
        end
      endcase
    end
  end

  // Press pulse is decoded from the same compares that drive the FSM, so
  // step_en lands on the edge the press is accepted.
  always_comb begin
    w_press = 1'b0;
    case (r_state)
      S_PRESS_DB: w_press = w_pb_s && (r_tc == DB_LAST);
`ifdef STEP_PULSE_AUTOREPEAT_EN
      S_HELD:     w_press = w_pb_s && (r_tc == REP_DLY_LAST);
      S_REPEAT:   w_press = w_pb_s && (r_tc == REP_PER_LAST);
`endif
      default:    w_press = 1'b0;
    endcase
  end

  // Free-run period counter; held at zero while the switch is off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rc        <= '0;
      r_run_pulse <= 1'b0;
    end else if (!w_run_s) begin
      r_rc        <= '0;
      r_run_pulse <= 1'b0;
    end else if (r_rc == RUN_LAST) begin
      r_rc        <= '0;
      r_run_pulse <= 1'b1;
    end else begin
      r_rc        <= r_rc + CNT_W'(1);
      r_run_pulse <= 1'b0;
    end
  end

  // Source select and pulse counter. Masking with the previous step_en keeps
  // pulses apart even when the run switch flips between two sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_en  <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_step_en <= (w_run_s ? r_run_pulse : w_press) & ~r_step_en;
      if (clr_cnt) begin
        r_step_cnt <= '0;
      end else if (r_step_en) begin
        r_step_cnt <= r_step_cnt + STEP_CNT_W'(1);
      end
    end
  end

  assign step_en  = r_step_en;
  assign pb_level = r_pb_level;
  assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen with DB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8, RUN_PERIOD=5. Edge numbers count posedges after reset release.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pb = 1'b0;
  logic        run = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        step_en;
  logic        pb_level;
  logic [15:0] step_cnt;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  step_pulse_gen #(
    .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .RUN_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .pb(pb), .run(run), .clr_cnt(clr_cnt),
    .step_en(step_en), .pb_level(pb_level), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus window, expected pulse edges (byte k = k-th pulse), pb_level window, final count.
  typedef struct packed {
    logic [7:0]      pb_on;
    logic [7:0]      pb_len;
    logic [15:0]     bounce;
    logic [7:0]      run_on;
    logic [7:0]      run_len;
    logic [7:0]      ncyc;
    logic [3:0]      np;
    logic [7:0][7:0] p;
    logic [7:0]      lvl_rise;
    logic [7:0]      lvl_fall;
    logic [15:0]     cnt;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs[NVEC];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b0;
    pb = 1'b0;
    run = 1'b0;
    clr_cnt = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   pb_on, pb_end, run_on, run_end, rise, fall;
    int   bad_lvl, dbl;
    logic prev;
    v = vecs[i];
    pb_on = int'(v.pb_on);   pb_end = pb_on + int'(v.pb_len);
    run_on = int'(v.run_on); run_end = run_on + int'(v.run_len);
    rise = int'(v.lvl_rise); fall = int'(v.lvl_fall);
    bad_lvl = 0; dbl = 0; prev = 1'b0;
    apply_reset();
    exp_q.delete();
    for (int k = 0; k < int'(v.np); k++) exp_q.push_back(int'(v.p[k]));
    for (int e = 0; e < int'(v.ncyc); e++) begin
      pb  = (e >= pb_on && e < pb_end) || (e < 16 && v.bounce[e]);
      run = (e >= run_on && e < run_end);
      tick();
      if (step_en) begin
        if (exp_q.size() == 0) chk($sformatf("vec%0d unexpected pulse edge", i), e, -1);
        else chk($sformatf("vec%0d pulse edge", i), e, exp_q.pop_front());
      end
      if (pb_level !== (e >= rise && e < fall)) bad_lvl++;
      if (step_en && prev) dbl++;
      prev = step_en;
    end
    chk($sformatf("vec%0d missing pulses", i), exp_q.size(), 0);
    chk($sformatf("vec%0d pb_level trace errors", i), bad_lvl, 0);
    chk($sformatf("vec%0d back-to-back pulses", i), dbl, 0);
    chk($sformatf("vec%0d step_cnt", i), int'(step_cnt), int'(v.cnt));
    exp_q.delete();
  endtask

  initial begin
    int npulse, pedge;

    // bounce reject: pb 1,0,1,0 in 2-cycle slices
    vecs[0] = '{8'd0, 8'd0, 16'h0033, 8'd0, 8'd0, 8'd20, 4'd0, 64'h0, 8'd0, 8'd0, 16'd0};
    // clean press edges 10..24
    vecs[1] = '{8'd10, 8'd15, 16'h0, 8'd0, 8'd0, 8'd40, 4'd1, 64'h10, 8'd16, 8'd31, 16'd1};
    // long hold edges 10..54
`ifdef STEP_PULSE_AUTOREPEAT_EN
    vecs[2] = '{8'd10, 8'd45, 16'h0, 8'd0, 8'd0, 8'd70, 4'd4, 64'h342C2410, 8'd16, 8'd61, 16'd4};
`else
    vecs[2] = '{8'd10, 8'd45, 16'h0, 8'd0, 8'd0, 8'd70, 4'd1, 64'h10, 8'd16, 8'd61, 16'd1};
`endif
    // free run for 30 cycles
    vecs[3] = '{8'd0, 8'd0, 16'h0, 8'd0, 8'd30, 8'd40, 4'd5, 64'h1B16110C07, 8'd0, 8'd0, 16'd5};
    // press during run mode is masked, level still tracks
    vecs[4] = '{8'd10, 8'd15, 16'h0, 8'd0, 8'd40, 8'd50, 4'd7, 64'h25201B16110C07, 8'd16, 8'd31, 16'd7};
    // release bounce back to HELD: no extra pulse, release debounce restarts
    vecs[5] = '{8'd0, 8'd10, 16'h1000, 8'd0, 8'd0, 8'd30, 4'd1, 64'h06, 8'd6, 8'd19, 16'd1};

    // reset state
    #2;
    chk("reset step_en", int'(step_en), 0);
    chk("reset pb_level", int'(pb_level), 0);
    chk("reset step_cnt", int'(step_cnt), 0);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // counter wrap and clear-wins, paced by run pulses at edges 7, 12, 17
    apply_reset();
    run = 1'b1;
    repeat (4) tick();                       // after edge 3
    force dut.r_step_cnt = 16'hFFFF;
    tick();                                  // after edge 4
    release dut.r_step_cnt;
    chk("preload step_cnt", int'(step_cnt), 16'hFFFF);
    repeat (3) tick();                       // after edge 7
    chk("wrap pulse step_en", int'(step_en), 1);
    tick();                                  // after edge 8
    chk("wrap step_cnt", int'(step_cnt), 0);
    repeat (4) tick();                       // after edge 12
    chk("clr pulse step_en", int'(step_en), 1);
    clr_cnt = 1'b1;
    tick();                                  // after edge 13
    clr_cnt = 1'b0;
    chk("clr over increment", int'(step_cnt), 0);
    repeat (5) tick();                       // after edge 18
    chk("count after clr", int'(step_cnt), 1);

    // async reset mid PRESS_DB, then press still held
    apply_reset();
    pb = 1'b1;
    repeat (8) tick();                       // after edge 7
    chk("pre-reset step_cnt", int'(step_cnt), 1);
    chk("pre-reset pb_level", int'(pb_level), 1);
    pb = 1'b0;
    repeat (8) tick();                       // after edge 15, back in IDLE
    pb = 1'b1;
    repeat (4) tick();                       // after edge 19, in PRESS_DB
    #3 rst = 1'b0;
    #1;
    chk("async rst step_cnt", int'(step_cnt), 0);
    chk("async rst pb_level", int'(pb_level), 0);
    chk("async rst step_en", int'(step_en), 0);
    tick();
    rst = 1'b1;
    npulse = 0;
    pedge = -1;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (step_en) begin
        npulse++;
        pedge = e;
      end
    end
    chk("post-reset pulse count", npulse, 1);
    chk("post-reset pulse edge", pedge, 6);

    // async reset mid run while step_en is high
    apply_reset();
    run = 1'b1;
    repeat (13) tick();                      // after edge 12
    chk("run step_en before rst", int'(step_en), 1);
    chk("run step_cnt before rst", int'(step_cnt), 1);
    #3 rst = 1'b0;
    #1;
    chk("run async rst step_en", int'(step_en), 0);
    chk("run async rst step_cnt", int'(step_cnt), 0);
    run = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
